wen_demux_seq: RTL and testbench

Registered, parametrised write-strobe demultiplexer for the RAM macro array. It accepts one write request per handshake, steers a DW-bit data word plus a timed strobe to one of NCH channels (or to all channels in broadcast mode), and enforces a programmable strobe width and recovery gap. It replaces the fixed 1-to-16 combinational bank-enable decode. It sits between the bus-side write controller and the per-bank write-enable inputs.

---
 rtl/wen_demux_seq_if.sv | 34 +++
 rtl/wen_demux_seq.sv | 137 +++++++++++++
 tb/tb_wen_demux_seq.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wen_demux_seq_if.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | wen_demux_seq_if                                                           |
// | Request/strobe bundle between the write controller and wen_demux_seq.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface wen_demux_seq_if #(
  parameter int SEL_W = 4,
  parameter int NCH   = 16,
  parameter int DW    = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic             in_bcast;
  logic [DW-1:0]    in_data;
  logic [NCH-1:0]   out_stb;
  logic [DW-1:0]    out_data;
  logic             busy;
  logic             err;
  logic [15:0]      acc_cnt;

  modport master (
    output in_valid, in_sel, in_bcast, in_data,
    input  in_ready, out_stb, out_data, busy, err, acc_cnt
  );

  modport slave (
    input  in_valid, in_sel, in_bcast, in_data,
    output in_ready, out_stb, out_data, busy, err, acc_cnt
  );
endinterface
`default_nettype wire

// File: rtl/wen_demux_seq.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | wen_demux_seq                                                              |
// | Registered write-strobe demux with programmable strobe width and recovery. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module wen_demux_seq #(
  parameter int SEL_W     = 4,
  parameter int NCH       = 16,
  parameter int DW        = 8,
  parameter int PULSE_LEN = 1,
  parameter int GAP_CYC   = 0
) (
  input wire             clk,
  input wire             rst,
  wen_demux_seq_if.slave bus
);
  localparam int CNT_MAX = (PULSE_LEN > GAP_CYC) ? PULSE_LEN : GAP_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] C_PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] C_GAP_LOAD   = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [SEL_W:0]   C_NCH        = (SEL_W + 1)'(NCH);
  localparam logic [NCH-1:0]   C_ALL        = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GAP    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]   stb_q, stb_d;
  logic [DW-1:0]    data_q, data_d;
  logic             err_q, err_d;
  logic [15:0]      acc_q, acc_d;

  logic             ready;
  logic             accept;
  logic             sel_bad;
  logic [NCH-1:0]   stb_new;

  // Ready is a function of state only, so it never loops back through in_valid.
  always_comb begin
    ready = 1'b0;
    if (!rst) begin
      if (state_q == S_IDLE) begin
        ready = 1'b1;
      end else if ((state_q == S_ACTIVE) && (cnt_q == '0) && (GAP_CYC == 0)) begin
        ready = 1'b1;
      end
    end
  end

  assign accept  = bus.in_valid & ready;
  assign sel_bad = ({1'b0, bus.in_sel} >= C_NCH) & ~bus.in_bcast;

  always_comb begin
    stb_new = '0;
    if (bus.in_bcast) begin
      stb_new = C_ALL;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        stb_new[i] = (bus.in_sel == SEL_W'(i));
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stb_d   = stb_q;
    data_d  = data_q;
    err_d   = err_q;
    acc_d   = acc_q;
    case (state_q)
      S_ACTIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (GAP_CYC > 0) begin
          state_d = S_GAP;
          cnt_d   = C_GAP_LOAD;
          stb_d   = '0;
        end else begin
          state_d = S_IDLE;
          stb_d   = '0;
        end
      end
      S_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase
    // An accept covers both the idle start and the zero-gap reload at count 0.
    if (accept) begin
      state_d = S_ACTIVE;
      cnt_d   = C_PULSE_LOAD;
      stb_d   = stb_new;
      data_d  = bus.in_data;
      acc_d   = acc_q + 16'd1;
      if (sel_bad) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      stb_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stb_q   <= stb_d;
      data_q  <= data_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
    end
  end

  assign bus.in_ready = ready;
  assign bus.out_stb  = stb_q;
  assign bus.out_data = data_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.err      = err_q;
  assign bus.acc_cnt  = acc_q;
endmodule
`default_nettype wire

// File: tb/tb_wen_demux_seq.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_wen_demux_seq                                                           |
// | Four parameterisations side by side against a time-window reference model. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_wen_demux_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Per-instance parameters: a, b, c, d
  int pl [4] = '{1, 2, 1, 4};
  int gp [4] = '{0, 0, 2, 1};
  int nc [4] = '{16, 16, 16, 12};

  logic        v   [4];
  logic [3:0]  sel [4];
  logic        bc  [4];
  logic [7:0]  dat [4];
  logic [15:0] o_stb [4];
  logic [7:0]  o_dat [4];
  logic        o_rdy [4];
  logic        o_bsy [4];
  logic        o_err [4];
  logic [15:0] o_acc [4];

  wen_demux_seq_if #(.SEL_W(4), .NCH(16), .DW(8)) if_a ();
  wen_demux_seq_if #(.SEL_W(4), .NCH(16), .DW(8)) if_b ();
  wen_demux_seq_if #(.SEL_W(4), .NCH(16), .DW(8)) if_c ();
  wen_demux_seq_if #(.SEL_W(4), .NCH(12), .DW(8)) if_d ();

  wen_demux_seq #(.SEL_W(4), .NCH(16), .DW(8), .PULSE_LEN(1), .GAP_CYC(0))
    dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  wen_demux_seq #(.SEL_W(4), .NCH(16), .DW(8), .PULSE_LEN(2), .GAP_CYC(0))
    dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  wen_demux_seq #(.SEL_W(4), .NCH(16), .DW(8), .PULSE_LEN(1), .GAP_CYC(2))
    dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));
  wen_demux_seq #(.SEL_W(4), .NCH(12), .DW(8), .PULSE_LEN(4), .GAP_CYC(1))
    dut_d (.clk(clk), .rst(rst), .bus(if_d.slave));

  assign if_a.in_valid = v[0];
  assign if_a.in_sel   = sel[0];
  assign if_a.in_bcast = bc[0];
  assign if_a.in_data  = dat[0];
  assign if_b.in_valid = v[1];
  assign if_b.in_sel   = sel[1];
  assign if_b.in_bcast = bc[1];
  assign if_b.in_data  = dat[1];
  assign if_c.in_valid = v[2];
  assign if_c.in_sel   = sel[2];
  assign if_c.in_bcast = bc[2];
  assign if_c.in_data  = dat[2];
  assign if_d.in_valid = v[3];
  assign if_d.in_sel   = sel[3];
  assign if_d.in_bcast = bc[3];
  assign if_d.in_data  = dat[3];

  assign o_stb[0] = if_a.out_stb;
  assign o_stb[1] = if_b.out_stb;
  assign o_stb[2] = if_c.out_stb;
  assign o_stb[3] = {4'b0000, if_d.out_stb};
  assign o_dat[0] = if_a.out_data;
  assign o_dat[1] = if_b.out_data;
  assign o_dat[2] = if_c.out_data;
  assign o_dat[3] = if_d.out_data;
  assign o_rdy[0] = if_a.in_ready;
  assign o_rdy[1] = if_b.in_ready;
  assign o_rdy[2] = if_c.in_ready;
  assign o_rdy[3] = if_d.in_ready;
  assign o_bsy[0] = if_a.busy;
  assign o_bsy[1] = if_b.busy;
  assign o_bsy[2] = if_c.busy;
  assign o_bsy[3] = if_d.busy;
  assign o_err[0] = if_a.err;
  assign o_err[1] = if_b.err;
  assign o_err[2] = if_c.err;
  assign o_err[3] = if_d.err;
  assign o_acc[0] = if_a.acc_cnt;
  assign o_acc[1] = if_b.acc_cnt;
  assign o_acc[2] = if_c.acc_cnt;
  assign o_acc[3] = if_d.acc_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: each instance is described by the edge of its last accept;
  // strobe, busy and ready are windows measured from that edge.
  localparam int NEVER = -1000000;
  int          m = 0;
  int          mk   [4] = '{NEVER, NEVER, NEVER, NEVER};
  logic [15:0] mstb [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
  logic [7:0]  mdat [4] = '{8'h0, 8'h0, 8'h0, 8'h0};
  logic        merr [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  logic [15:0] macc [4] = '{16'h0, 16'h0, 16'h0, 16'h0};

  function automatic int thr(input int i);
    return (gp[i] > 0) ? pl[i] + gp[i] : pl[i] - 1;
  endfunction

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d @edge %0d: got 0x%0h, expected 0x%0h", nm, id, m, act, exp);
    end
  endtask

  task automatic model_edge();
    m++;
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        mk[i] = NEVER; mstb[i] = '0; mdat[i] = '0; merr[i] = 1'b0; macc[i] = '0;
      end else if (v[i] && ((m - 1 - mk[i]) >= thr(i))) begin
        mk[i]   = m;
        mdat[i] = dat[i];
        macc[i] = macc[i] + 16'd1;
        if (bc[i])
          mstb[i] = 16'((1 << nc[i]) - 1);
        else if (int'(sel[i]) < nc[i])
          mstb[i] = 16'(1 << sel[i]);
        else begin
          mstb[i] = '0;
          merr[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic model_cmp();
    for (int i = 0; i < 4; i++) begin
      int age;
      age = m - mk[i];
      chk("stb",  i, 32'(o_stb[i]), (age < pl[i]) ? 32'(mstb[i]) : 32'h0);
      chk("data", i, 32'(o_dat[i]), 32'(mdat[i]));
      chk("busy", i, 32'(o_bsy[i]), 32'(age < pl[i] + gp[i]));
      chk("rdy",  i, 32'(o_rdy[i]), 32'(!rst && (age >= thr(i))));
      chk("err",  i, 32'(o_err[i]), 32'(merr[i]));
      chk("acc",  i, 32'(o_acc[i]), 32'(macc[i]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    model_cmp();
  endtask

  task automatic rand_in(input int first);
    for (int i = first; i < 4; i++) begin
      v[i]   = 1'($urandom_range(0, 1));
      sel[i] = 4'($urandom);
      bc[i]  = ($urandom_range(0, 7) == 0);
      dat[i] = 8'($urandom);
    end
  endtask

  typedef struct {
    logic        v;
    logic [3:0]  sel;
    logic        bc;
    logic [7:0]  d;
    logic [15:0] stb;
    logic [7:0]  dat;
    logic        busy;
    logic        rdy;
    logic [15:0] acc;
  } vec_t;

  vec_t tbl [7];

  initial begin
    tbl[0] = '{1'b1, 4'd5,  1'b0, 8'hA5, 16'h0020, 8'hA5, 1'b1, 1'b1, 16'd1};
    tbl[1] = '{1'b0, 4'd6,  1'b0, 8'h00, 16'h0000, 8'hA5, 1'b0, 1'b1, 16'd1};
    tbl[2] = '{1'b1, 4'd2,  1'b1, 8'h3C, 16'hFFFF, 8'h3C, 1'b1, 1'b1, 16'd2};
    tbl[3] = '{1'b1, 4'd7,  1'b0, 8'h11, 16'h0080, 8'h11, 1'b1, 1'b1, 16'd3};
    tbl[4] = '{1'b0, 4'd9,  1'b0, 8'hFF, 16'h0000, 8'h11, 1'b0, 1'b1, 16'd3};
    tbl[5] = '{1'b1, 4'd15, 1'b0, 8'h42, 16'h8000, 8'h42, 1'b1, 1'b1, 16'd4};
    tbl[6] = '{1'b0, 4'd15, 1'b0, 8'h00, 16'h0000, 8'h42, 1'b0, 1'b1, 16'd4};

    for (int i = 0; i < 4; i++) begin
      v[i] = 1'b0; sel[i] = '0; bc[i] = 1'b0; dat[i] = '0;
    end

    // Reset held for three edges
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_stb",  0, 32'(o_stb[0]), 32'h0);
      chk("rst_data", 0, 32'(o_dat[0]), 32'h0);
      chk("rst_busy", 0, 32'(o_bsy[0]), 32'h0);
      chk("rst_err",  0, 32'(o_err[0]), 32'h0);
      chk("rst_acc",  0, 32'(o_acc[0]), 32'h0);
      chk("rst_rdy",  0, 32'(o_rdy[0]), 32'h0);
    end
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", 0, 32'(o_rdy[0]), 32'h1);

    // Table-driven single and back-to-back writes on PULSE_LEN=1, GAP_CYC=0
    for (int t = 0; t < 7; t++) begin
      v[0] = tbl[t].v; sel[0] = tbl[t].sel; bc[0] = tbl[t].bc; dat[0] = tbl[t].d;
      step();
      chk("tbl_stb",  t, 32'(o_stb[0]), 32'(tbl[t].stb));
      chk("tbl_data", t, 32'(o_dat[0]), 32'(tbl[t].dat));
      chk("tbl_busy", t, 32'(o_bsy[0]), 32'(tbl[t].busy));
      chk("tbl_rdy",  t, 32'(o_rdy[0]), 32'(tbl[t].rdy));
      chk("tbl_acc",  t, 32'(o_acc[0]), 32'(tbl[t].acc));
    end
    v[0] = 1'b0;

    // PULSE_LEN=2 back-to-back: 0x0008 x2 then 0x0200 x2, no dead cycle
    v[1] = 1'b1; sel[1] = 4'd3; dat[1] = 8'h33;
    step();
    chk("b2b_stb0", 1, 32'(o_stb[1]), 32'h0008);
    chk("b2b_rdy0", 1, 32'(o_rdy[1]), 32'h0);
    sel[1] = 4'd9; dat[1] = 8'h99;
    step();
    chk("b2b_stb1", 1, 32'(o_stb[1]), 32'h0008);
    chk("b2b_rdy1", 1, 32'(o_rdy[1]), 32'h1);
    step();
    chk("b2b_stb2", 1, 32'(o_stb[1]), 32'h0200);
    chk("b2b_dat2", 1, 32'(o_dat[1]), 32'h99);
    v[1] = 1'b0;
    step();
    chk("b2b_stb3", 1, 32'(o_stb[1]), 32'h0200);
    step();
    chk("b2b_stb4", 1, 32'(o_stb[1]), 32'h0);
    chk("b2b_acc",  1, 32'(o_acc[1]), 32'd2);

    // Broadcast with GAP_CYC=2, second request held valid throughout
    v[2] = 1'b1; bc[2] = 1'b1; dat[2] = 8'h5A;
    step();
    chk("gap_stb0", 2, 32'(o_stb[2]), 32'hFFFF);
    chk("gap_rdy0", 2, 32'(o_rdy[2]), 32'h0);
    bc[2] = 1'b0; sel[2] = 4'd6; dat[2] = 8'h66;
    for (int k = 1; k <= 2; k++) begin
      step();
      chk("gap_stb", 2, 32'(o_stb[2]), 32'h0);
      chk("gap_busy", 2, 32'(o_bsy[2]), 32'h1);
      chk("gap_rdy", 2, 32'(o_rdy[2]), 32'h0);
      chk("gap_dat", 2, 32'(o_dat[2]), 32'h5A);
    end
    step();
    chk("gap_busy3", 2, 32'(o_bsy[2]), 32'h0);
    chk("gap_rdy3",  2, 32'(o_rdy[2]), 32'h1);
    step();
    v[2] = 1'b0;
    chk("gap_stb4", 2, 32'(o_stb[2]), 32'h0040);
    chk("gap_dat4", 2, 32'(o_dat[2]), 32'h66);

    // NCH=12: select 14 is out of range
    v[3] = 1'b1; sel[3] = 4'd14; dat[3] = 8'hE1;
    step();
    v[3] = 1'b0;
    chk("oor_stb", 3, 32'(o_stb[3]), 32'h0);
    chk("oor_err", 3, 32'(o_err[3]), 32'h1);
    chk("oor_acc", 3, 32'(o_acc[3]), 32'd1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("oor_err_hold", 3, 32'(o_err[3]), 32'h1);
    end

    // Reset during the second ACTIVE cycle of a PULSE_LEN=4 strobe
    v[3] = 1'b1; sel[3] = 4'd3; dat[3] = 8'h77;
    step();
    v[3] = 1'b0;
    chk("mid_stb0", 3, 32'(o_stb[3]), 32'h0008);
    step();
    chk("mid_stb1", 3, 32'(o_stb[3]), 32'h0008);
    rst = 1'b1;
    step();
    chk("mid_rst_stb",  3, 32'(o_stb[3]), 32'h0);
    chk("mid_rst_busy", 3, 32'(o_bsy[3]), 32'h0);
    chk("mid_rst_err",  3, 32'(o_err[3]), 32'h0);
    rst = 1'b0;

    // Randomised traffic on all instances, with occasional resets
    for (int k = 0; k < 2000; k++) begin
      rand_in(0);
      rst = ($urandom_range(0, 149) == 0);
      step();
    end

    // Counter wrap: 0xFFFF accepts, then one more
    rst = 1'b1;
    rand_in(1);
    step();
    rst = 1'b0;
    for (int k = 0; k < 65535; k++) begin
      v[0] = 1'b1; sel[0] = 4'($urandom); bc[0] = 1'b0; dat[0] = 8'($urandom);
      rand_in(1);
      step();
    end
    chk("wrap_ffff", 0, 32'(o_acc[0]), 32'hFFFF);
    step();
    chk("wrap_zero", 0, 32'(o_acc[0]), 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
